audio_fade_ramp_ctrl: RTL and testbench
=======================================

// Module: audio_fade_ramp_ctrl
// PURPOSE
//  Gain sequencer for the audio fader datapath. Accepts a target gain and a
//  per-sample step rate from the AXI4-Lite register bank. Once per sample
//  strobe it moves the applied gain linearly toward the target. Sits between
//  the fader slave registers and the gain multiplier, so software changes
//  never produce zipper noise.
// PARAMETERS
//  GAIN_W       16   gain width, unsigned fixed point (0 = mute, max = 2^GAIN_W-1)
//  ZC_TIMEOUT   64   max sample ticks to wait for a zero crossing (AUDIO_FADER_ZC_EN only)
// PORTS
//  ACLK          in   1       clock; all logic on rising edge
//  ARESETN       in   1       asynchronous, active-low reset
//  cfg_valid     in   1       new target/rate presented
//  cfg_ready     out  1       always 1 out of reset; cfg accepted when cfg_valid & cfg_ready
//  cfg_target    in   GAIN_W  target gain
//  cfg_rate      in   GAIN_W  gain change per sample tick; 0 = immediate jump
//  abort         in   1       freeze gain at current value, return to IDLE
//  sample_tick   in   1       one-cycle strobe per audio sample (fs)
//  sample_msb    in   1       sign bit of current sample (AUDIO_FADER_ZC_EN only)
//  gain_out      out  GAIN_W  registered gain to multiplier
//  ramp_active   out  1       1 while state != IDLE
//  done          out  1       one-cycle pulse when gain_out reaches cfg_target
// BEHAVIOUR
//  Reset (async, immediate)
//   - gain_out=0, target_q=0, rate_q=0, state=IDLE, done=0, ramp_active=0, cfg_ready=0.
//   - cfg_ready rises 1 cycle after ARESETN deasserts.
//   - Reset mid-ramp discards the ramp; no done pulse.
//  States: IDLE, RAMP_UP, RAMP_DN
//  Config accept in cycle N
//   - target_q/rate_q are latched.
//   - Next state at N+1: RAMP_UP if target>gain_out, RAMP_DN if target<gain_out.
//   - If target==gain_out: IDLE, done=1 at N+1.
//   - rate=0 and target!=gain_out: gain_out=target and done=1 at N+1, state IDLE.
//   - Accept is legal in any state. Mid-ramp retarget continues from the current
//     gain_out with no discontinuity.
//  Stepping
//   - Only on sample_tick in a RAMP state. gain_out updates the cycle after the tick.
//   - RAMP_UP: nxt = gain_out + rate_q, computed GAIN_W+1 wide.
//     If nxt >= target_q, gain_out=target_q. No wrap, saturates at target.
//   - RAMP_DN: if gain_out - rate_q <= target_q (signed GAIN_W+1 compare, no
//     underflow), gain_out=target_q.
//   - Reaching target: done=1 in the same cycle gain_out takes target_q; next state IDLE.
//   - sample_tick in IDLE: ignored.
//  Simultaneous events
//   - cfg accept + sample_tick: cfg wins, no step that cycle.
//   - abort + cfg accept: abort wins, cfg dropped, gain_out held.
//   - abort: state IDLE next cycle, gain_out unchanged, no done.
// CONFIGURATION
//  AUDIO_FADER_ZC_EN defined
//   - sample_msb port exists.
//   - A pending step is applied only on a sample_tick where sample_msb differs
//     from its value at the previous tick (zero crossing).
//   - Or after ZC_TIMEOUT ticks without a crossing; the counter resets on every
//     applied step and on cfg accept.
//   - rate=0 jumps also wait for a crossing or the timeout.
//  AUDIO_FADER_ZC_EN undefined
//   - No sample_msb port, no timeout counter.
//   - Every sample_tick in a RAMP state steps.
// TESTING (GAIN_W=16)
//  1 Reset:
//     - Assert ARESETN=0 mid-ramp -> gain_out=0x0000, ramp_active=0, done=0 the same cycle.
//     - cfg_ready=1 one cycle after release.
//  2 Ramp up:
//     - From 0, cfg target=0x1000, rate=0x0400, then 4 ticks.
//     - -> gain_out 0x0400, 0x0800, 0x0C00, 0x1000.
//     - done pulses once with 0x1000; ramp_active=0 after.
//  3 Clamp down:
//     - From 0x1000, target=0x0300, rate=0x0800.
//     - -> 0x0800, then 0x0300 (not 0x0000); done on the second tick.
//  4 Jump and equal target:
//     - rate=0, target=0xFFFF from 0 -> gain_out=0xFFFF and done at N+1.
//     - Re-send the same target -> done at N+1, no gain change.
//  5 Retarget / abort:
//     - Mid-ramp at 0x0800, cfg target=0x0000 with sample_tick in the same cycle
//       -> no step that cycle; RAMP_DN from 0x0800.
//     - abort at 0x0400 -> gain holds 0x0400, IDLE, no done.
//  6 ZC (AUDIO_FADER_ZC_EN, ZC_TIMEOUT=4):
//     - Ramp with constant sample_msb=0 -> steps only every 4th tick.
//     - Toggle msb -> step on the toggle tick.

Source files
------------

// File: rtl/audio_fade_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : audio_fade_ramp_ctrl
//  Brief    : Gain sequencer between the fader register bank and the gain
//             multiplier. Once per sample strobe the applied gain moves
//             linearly toward the programmed target, saturating exactly on
//             the target so software writes never cause zipper noise.
//  Options  : AUDIO_FADER_ZC_EN - defer each gain step to a zero crossing of
//             the audio sample (or to a ZC_TIMEOUT-tick timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module audio_fade_ramp_ctrl #(
    parameter int GAIN_W     = 16
`ifdef AUDIO_FADER_ZC_EN
    ,
    parameter int ZC_TIMEOUT = 64
`endif
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [GAIN_W-1:0] cfg_target,
    input  logic [GAIN_W-1:0] cfg_rate,
    input  logic              abort,
    input  logic              sample_tick,
`ifdef AUDIO_FADER_ZC_EN
    input  logic              sample_msb,
`endif
    output logic [GAIN_W-1:0] gain_out,
    output logic              ramp_active,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_RAMP_DN = 2'd2
    } state_t;

    state_t            state_q,       state_d;
    logic [GAIN_W-1:0] gain_q,        gain_d;
    logic [GAIN_W-1:0] target_q,      target_d;
    logic [GAIN_W-1:0] rate_q,        rate_d;
    logic              done_q,        done_d;
    logic              cfg_ready_q,   cfg_ready_d;
    logic              ramp_active_q, ramp_active_d;

    logic              cfg_accept;
    logic              step_ok;
    logic [GAIN_W:0]   up_sum;
    logic [GAIN_W:0]   dn_diff;
    logic              up_hit;
    logic              dn_hit;

`ifdef AUDIO_FADER_ZC_EN
    localparam int              ZC_CNT_W = $clog2(ZC_TIMEOUT + 1);
    localparam logic [ZC_CNT_W-1:0] ZC_LAST = ZC_CNT_W'(ZC_TIMEOUT - 1);

    logic                msb_prev_q, msb_prev_d;
    logic [ZC_CNT_W-1:0] zc_cnt_q,   zc_cnt_d;
`endif

    assign cfg_accept = cfg_valid & cfg_ready_q;

    // Candidate next gain in both directions, one bit wider so neither the
    // sum can wrap nor the difference can underflow past zero.
    always_comb begin
        up_sum  = {1'b0, gain_q} + {1'b0, rate_q};
        dn_diff = {1'b0, gain_q} - {1'b0, rate_q};
        // A zero rate can only reach a ramp state when jumps wait for a
        // zero crossing; treat it as a full jump to the target.
        up_hit  = (rate_q == '0) || (up_sum >= {1'b0, target_q});
        dn_hit  = (rate_q == '0) || ($signed(dn_diff) <= $signed({1'b0, target_q}));
    end

`ifdef AUDIO_FADER_ZC_EN
    // A tick may apply a step only on a sign change or after the timeout.
    assign step_ok = (sample_msb != msb_prev_q) || (zc_cnt_q >= ZC_LAST);
`else
    assign step_ok = 1'b1;
`endif

    // Next-state logic: abort beats config, config beats a step.
    always_comb begin
        state_d     = state_q;
        gain_d      = gain_q;
        target_d    = target_q;
        rate_d      = rate_q;
        done_d      = 1'b0;
        cfg_ready_d = 1'b1;
`ifdef AUDIO_FADER_ZC_EN
        msb_prev_d  = sample_tick ? sample_msb : msb_prev_q;
        zc_cnt_d    = zc_cnt_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
        end else if (cfg_accept) begin
            target_d = cfg_target;
            rate_d   = cfg_rate;
`ifdef AUDIO_FADER_ZC_EN
            zc_cnt_d = '0;
`endif
            if (cfg_target == gain_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
`ifndef AUDIO_FADER_ZC_EN
            end else if (cfg_rate == '0) begin
                gain_d  = cfg_target;
                state_d = ST_IDLE;
                done_d  = 1'b1;
`endif
            end else if (cfg_target > gain_q) begin
                state_d = ST_RAMP_UP;
            end else begin
                state_d = ST_RAMP_DN;
            end
        end else if (sample_tick && (state_q != ST_IDLE)) begin
            if (step_ok) begin
`ifdef AUDIO_FADER_ZC_EN
                zc_cnt_d = '0;
`endif
                if (state_q == ST_RAMP_UP) begin
                    if (up_hit) begin
                        gain_d  = target_q;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        gain_d  = up_sum[GAIN_W-1:0];
                    end
                end else begin
                    if (dn_hit) begin
                        gain_d  = target_q;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        gain_d  = dn_diff[GAIN_W-1:0];
                    end
                end
            end else begin
`ifdef AUDIO_FADER_ZC_EN
                zc_cnt_d = zc_cnt_q + 1'b1;
`endif
            end
        end
        ramp_active_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset drops any ramp in progress.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= ST_IDLE;
            gain_q        <= '0;
            target_q      <= '0;
            rate_q        <= '0;
            done_q        <= 1'b0;
            cfg_ready_q   <= 1'b0;
            ramp_active_q <= 1'b0;
`ifdef AUDIO_FADER_ZC_EN
            msb_prev_q    <= 1'b0;
            zc_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            gain_q        <= gain_d;
            target_q      <= target_d;
            rate_q        <= rate_d;
            done_q        <= done_d;
            cfg_ready_q   <= cfg_ready_d;
            ramp_active_q <= ramp_active_d;
`ifdef AUDIO_FADER_ZC_EN
            msb_prev_q    <= msb_prev_d;
            zc_cnt_q      <= zc_cnt_d;
`endif
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign gain_out    = gain_q;
    assign ramp_active = ramp_active_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_fade_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_fade_ramp_ctrl
//  Brief    : Directed self-checking bench for audio_fade_ramp_ctrl
//             (GAIN_W=16; ZC_TIMEOUT=4 when AUDIO_FADER_ZC_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_audio_fade_ramp_ctrl;

    localparam int GAIN_W = 16;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [GAIN_W-1:0] cfg_target;
    logic [GAIN_W-1:0] cfg_rate;
    logic              abort;
    logic              sample_tick;
    logic              sample_msb;
    logic [GAIN_W-1:0] gain_out;
    logic              ramp_active;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    audio_fade_ramp_ctrl #(
        .GAIN_W     (GAIN_W)
`ifdef AUDIO_FADER_ZC_EN
        ,
        .ZC_TIMEOUT (4)
`endif
    ) dut (
        .ACLK        (aclk),
        .ARESETN     (aresetn),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_target  (cfg_target),
        .cfg_rate    (cfg_rate),
        .abort       (abort),
        .sample_tick (sample_tick),
`ifdef AUDIO_FADER_ZC_EN
        .sample_msb  (sample_msb),
`endif
        .gain_out    (gain_out),
        .ramp_active (ramp_active),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic cfg(input logic [GAIN_W-1:0] tgt, input logic [GAIN_W-1:0] rate);
        cfg_valid  = 1'b1;
        cfg_target = tgt;
        cfg_rate   = rate;
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic tick(input logic msb);
        sample_tick = 1'b1;
        sample_msb  = msb;
        step();
        sample_tick = 1'b0;
    endtask

    initial begin
        aresetn     = 1'b0;
        cfg_valid   = 1'b0;
        cfg_target  = '0;
        cfg_rate    = '0;
        abort       = 1'b0;
        sample_tick = 1'b0;
        sample_msb  = 1'b0;

        // Reset state
        #12;
        chk("rst_gain", 32'(gain_out), 32'h0);
        chk("rst_active", 32'(ramp_active), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h0);
        step();
        aresetn = 1'b1;
        chk("rel_ready_0", 32'(cfg_ready), 32'h0);
        step();
        chk("rel_ready_1", 32'(cfg_ready), 32'h1);

`ifndef AUDIO_FADER_ZC_EN
        // Ramp up 0 -> 0x1000 in 0x0400 steps
        cfg(16'h1000, 16'h0400);
        chk("up_active", 32'(ramp_active), 32'h1);
        chk("up_gain0", 32'(gain_out), 32'h0);
        tick(1'b0);
        chk("up_g1", 32'(gain_out), 32'h0400);
        step();
        chk("up_hold_between_ticks", 32'(gain_out), 32'h0400);
        tick(1'b0);
        chk("up_g2", 32'(gain_out), 32'h0800);
        tick(1'b0);
        chk("up_g3", 32'(gain_out), 32'h0C00);
        chk("up_done_early", 32'(done), 32'h0);
        tick(1'b0);
        chk("up_g4", 32'(gain_out), 32'h1000);
        chk("up_done", 32'(done), 32'h1);
        chk("up_idle", 32'(ramp_active), 32'h0);
        step();
        chk("up_done_pulse", 32'(done), 32'h0);
        tick(1'b0);
        chk("idle_tick_ignored", 32'(gain_out), 32'h1000);

        // Clamp down 0x1000 -> 0x0300 in 0x0800 steps
        cfg(16'h0300, 16'h0800);
        chk("dn_active", 32'(ramp_active), 32'h1);
        tick(1'b0);
        chk("dn_g1", 32'(gain_out), 32'h0800);
        chk("dn_done_early", 32'(done), 32'h0);
        tick(1'b0);
        chk("dn_clamp", 32'(gain_out), 32'h0300);
        chk("dn_done", 32'(done), 32'h1);
        chk("dn_idle", 32'(ramp_active), 32'h0);

        // Jumps with rate 0, then re-send the same target
        cfg(16'h0000, 16'h0000);
        chk("jump0_gain", 32'(gain_out), 32'h0);
        chk("jump0_done", 32'(done), 32'h1);
        cfg(16'hFFFF, 16'h0000);
        chk("jumpF_gain", 32'(gain_out), 32'hFFFF);
        chk("jumpF_done", 32'(done), 32'h1);
        chk("jumpF_idle", 32'(ramp_active), 32'h0);
        step();
        chk("jumpF_done_pulse", 32'(done), 32'h0);
        cfg(16'hFFFF, 16'h0400);
        chk("same_gain", 32'(gain_out), 32'hFFFF);
        chk("same_done", 32'(done), 32'h1);
        chk("same_idle", 32'(ramp_active), 32'h0);

        // Retarget mid-ramp with a simultaneous tick, then abort
        cfg(16'h0000, 16'h0000);
        cfg(16'h1000, 16'h0400);
        tick(1'b0);
        tick(1'b0);
        chk("rt_at_800", 32'(gain_out), 32'h0800);
        cfg_valid   = 1'b1;
        cfg_target  = 16'h0000;
        cfg_rate    = 16'h0400;
        sample_tick = 1'b1;
        step();
        cfg_valid   = 1'b0;
        sample_tick = 1'b0;
        chk("rt_no_step", 32'(gain_out), 32'h0800);
        chk("rt_active", 32'(ramp_active), 32'h1);
        chk("rt_no_done", 32'(done), 32'h0);
        tick(1'b0);
        chk("rt_dn_step", 32'(gain_out), 32'h0400);
        abort       = 1'b1;
        cfg_valid   = 1'b1;
        cfg_target  = 16'hFFFF;
        cfg_rate    = 16'h0000;
        sample_tick = 1'b1;
        step();
        abort       = 1'b0;
        cfg_valid   = 1'b0;
        sample_tick = 1'b0;
        chk("abort_gain", 32'(gain_out), 32'h0400);
        chk("abort_idle", 32'(ramp_active), 32'h0);
        chk("abort_no_done", 32'(done), 32'h0);
        tick(1'b0);
        chk("abort_hold", 32'(gain_out), 32'h0400);
`else
        // Zero-crossing gated stepping, timeout of 4 ticks
        cfg(16'h1000, 16'h0400);
        chk("zc_active", 32'(ramp_active), 32'h1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        chk("zc_wait3", 32'(gain_out), 32'h0);
        tick(1'b0);
        chk("zc_timeout_step", 32'(gain_out), 32'h0400);
        tick(1'b1);
        chk("zc_cross_step", 32'(gain_out), 32'h0800);
        tick(1'b1);
        chk("zc_no_cross", 32'(gain_out), 32'h0800);
        tick(1'b0);
        chk("zc_cross_step2", 32'(gain_out), 32'h0C00);
        cfg(16'h0000, 16'h0000);
        chk("zc_jump_waits", 32'(gain_out), 32'h0C00);
        tick(1'b1);
        chk("zc_jump_gain", 32'(gain_out), 32'h0000);
        chk("zc_jump_done", 32'(done), 32'h1);
`endif

        // Asynchronous reset in the middle of a ramp
        cfg(16'h1000, 16'h0100);
        chk("mr_active", 32'(ramp_active), 32'h1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mr_gain", 32'(gain_out), 32'h0);
        chk("mr_active0", 32'(ramp_active), 32'h0);
        chk("mr_done", 32'(done), 32'h0);
        chk("mr_ready", 32'(cfg_ready), 32'h0);
        step();
        aresetn = 1'b1;
        chk("mr_rel_ready_0", 32'(cfg_ready), 32'h0);
        step();
        chk("mr_rel_ready_1", 32'(cfg_ready), 32'h1);
        chk("mr_rel_done", 32'(done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
